warp_context_ctrl: RTL and testbench
====================================

# warp_context_ctrl

Parametrised per-warp context store for the SIMT core, sitting between the warp scheduler, the writeback/branch unit and the barrier logic. It holds PC, active mask, status and age for every warp, and adds three behaviours: timed stalls with a per-warp countdown, CTA-wide barrier arrival and release, and explicit kill. Simultaneous updates to the same warp resolve under a fixed priority. All state is exported flat so the scheduler can read every warp in parallel.

## Interface
- NUM_WARPS, 8, number of warp slots (≥2); WID_W = $clog2(NUM_WARPS)
- WARP_SIZE, 32, threads per warp / mask width
- PC_WIDTH, 32, program counter width
- AGE_WIDTH, 8, saturating age counter width
- STALL_WIDTH, 6, stall countdown width

- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- init_valid / init_id / init_pc / init_mask  in  1 / WID_W / PC_WIDTH / WARP_SIZE  launch warp
- commit_valid / commit_id / commit_pc  in  1 / WID_W / PC_WIDTH  retire instruction, write next PC
- commit_mask_we / commit_mask  in  1 / WARP_SIZE  optional mask write with commit
- stall_valid / stall_id / stall_cycles  in  1 / WID_W / STALL_WIDTH  timed stall request
- bar_valid / bar_id  in  1 / WID_W  barrier arrival
- kill_valid / kill_id  in  1 / WID_W  force warp DONE
- issue_valid / issue_id  in  1 / WID_W  scheduler issued this warp
- pc_flat  out  NUM_WARPS*PC_WIDTH  warp i at [i*PC_WIDTH +: PC_WIDTH]
- mask_flat  out  NUM_WARPS*WARP_SIZE  per-warp active mask
- status_flat  out  NUM_WARPS*3  per-warp status
- age_flat  out  NUM_WARPS*AGE_WIDTH  per-warp age
- valid_mask / ready_mask / done_mask  out  NUM_WARPS each  per-warp flags
- all_done  out  1  every valid warp DONE and ≥1 valid
- bar_release  out  1  one-cycle pulse on barrier release

## Operation
- Status codes: IDLE=0, READY=1, STALLED=2, BARRIER=3, DONE=4.
- Reset: all PC, mask, age, and stall counters are 0. All status IDLE, valid 0. bar_release 0, all_done 0, every mask output 0.
- init: pc, mask load. status READY, age 0, stall counter 0, valid 1. Init on an already-valid warp overwrites it.
- Commands other than init to a warp with valid=0 or status DONE are ignored.
- commit: pc ← commit_pc. If commit_mask_we, mask ← commit_mask; a zero mask sets DONE.
- stall: stall_cycles=0 is ignored. Otherwise status STALLED, counter ← stall_cycles. Counter decrements each cycle. At the edge where counter==1 the warp becomes READY and the counter becomes 0.
- bar: status BARRIER.
- Release condition, evaluated on registered state: ≥1 warp in BARRIER, and every valid non-DONE warp is BARRIER. At the next edge, all BARRIER warps become READY and bar_release=1 for that one cycle.
- kill: status DONE; mask unchanged.
- Same-warp priority within one cycle, highest first: init > kill > commit-to-DONE > stall > bar > stall expiry > barrier release. A lower-priority status change is discarded. commit PC/mask writes apply unless init or kill hits the same warp.
- A bar arrival in the cycle a release fires: the arriving warp ends in BARRIER, not released.
- Age, only when issue_valid: the issued warp's age ← 0. Every other valid warp that is READY at cycle start gets age+1, saturating at 2^AGE_WIDTH−1. Init age 0 wins over increment.
- Different warps may receive different commands in the same cycle, all applied.

## Timing
- Every update takes effect at the next rising clk edge. Outputs are driven directly from flops; there is no combinational input→output path.
- Stall of N cycles: request at edge t → STALLED from t, READY visible after edge t+N.
- Barrier: last arrival at edge t → release condition true during cycle t. Warps READY and bar_release high after edge t+1; bar_release low after t+2.
- rst asserted mid-operation clears everything asynchronously, including in-flight stall counters and pending releases.

## Test plan
- Reset then init warp 2 (pc 0x100, mask 0xFFFF_FFFF) → status 1, valid_mask=0x04, ready_mask=0x04, age 0.
- Stall warp 1 for 3 cycles → status 2 for exactly 3 cycles, then READY. stall_cycles=0 → no change.
- Warps 0,1,3 valid; bar 0 then 1 then 3 → single bar_release pulse one cycle after warp 3 arrives, all three READY. DONE warp 5 does not block release.
- Same cycle: kill warp 4 + commit warp 4 (pc 0x40) + stall warp 4 → status 4, pc unchanged. Commit with mask 0 → DONE.
- Issue warp 0 repeatedly with warp 1 READY → warp 1 age saturates at 255 (AGE_WIDTH=8). A STALLED warp's age does not increment.
- Assert rst during an active stall (counter 5) and pending barrier → all state zero/IDLE immediately, no bar_release after rst is released.

Source files
------------

// File: rtl/warp_context_ctrl.sv
// Per-warp context store: PC, active mask, status and age for every warp slot.
// Timed stalls, CTA barrier arrival/release and kill resolve under a fixed per-warp priority.
module warp_context_ctrl #(
  parameter  int NUM_WARPS   = 8,
  parameter  int WARP_SIZE   = 32,
  parameter  int PC_WIDTH    = 32,
  parameter  int AGE_WIDTH   = 8,
  parameter  int STALL_WIDTH = 6,
  localparam int WID_W       = $clog2(NUM_WARPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init_valid,
  input  logic [WID_W-1:0]               init_id,
  input  logic [PC_WIDTH-1:0]            init_pc,
  input  logic [WARP_SIZE-1:0]           init_mask,
  input  logic                           commit_valid,
  input  logic [WID_W-1:0]               commit_id,
  input  logic [PC_WIDTH-1:0]            commit_pc,
  input  logic                           commit_mask_we,
  input  logic [WARP_SIZE-1:0]           commit_mask,
  input  logic                           stall_valid,
  input  logic [WID_W-1:0]               stall_id,
  input  logic [STALL_WIDTH-1:0]         stall_cycles,
  input  logic                           bar_valid,
  input  logic [WID_W-1:0]               bar_id,
  input  logic                           kill_valid,
  input  logic [WID_W-1:0]               kill_id,
  input  logic                           issue_valid,
  input  logic [WID_W-1:0]               issue_id,
  output logic [NUM_WARPS*PC_WIDTH-1:0]  pc_flat,
  output logic [NUM_WARPS*WARP_SIZE-1:0] mask_flat,
  output logic [NUM_WARPS*3-1:0]         status_flat,
  output logic [NUM_WARPS*AGE_WIDTH-1:0] age_flat,
  output logic [NUM_WARPS-1:0]           valid_mask,
  output logic [NUM_WARPS-1:0]           ready_mask,
  output logic [NUM_WARPS-1:0]           done_mask,
  output logic                           all_done,
  output logic                           bar_release
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_STALLED = 3'd2,
    ST_BARRIER = 3'd3,
    ST_DONE    = 3'd4
  } status_t;

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

  logic [PC_WIDTH-1:0]    pc_q     [NUM_WARPS];
  logic [PC_WIDTH-1:0]    pc_d     [NUM_WARPS];
  logic [WARP_SIZE-1:0]   mask_q   [NUM_WARPS];
  logic [WARP_SIZE-1:0]   mask_d   [NUM_WARPS];
  status_t                status_q [NUM_WARPS];
  status_t                status_d [NUM_WARPS];
  logic [AGE_WIDTH-1:0]   age_q    [NUM_WARPS];
  logic [AGE_WIDTH-1:0]   age_d    [NUM_WARPS];
  logic [STALL_WIDTH-1:0] cnt_q    [NUM_WARPS];
  logic [STALL_WIDTH-1:0] cnt_d    [NUM_WARPS];
  logic [NUM_WARPS-1:0]   valid_q, valid_d;

  logic [NUM_WARPS-1:0] live, hit_init, hit_kill, hit_commit, hit_stall, hit_bar, hit_issue;
  logic                 rel_any, rel_block, rel_fire;

  // Release looks only at registered state, so a same-cycle arrival is not released.
  always_comb begin
    rel_any   = 1'b0;
    rel_block = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (valid_q[i] && status_q[i] == ST_BARRIER) rel_any = 1'b1;
      if (valid_q[i] && status_q[i] != ST_BARRIER && status_q[i] != ST_DONE) rel_block = 1'b1;
    end
    rel_fire = rel_any & ~rel_block;
  end

  always_comb begin
    live       = '0;
    hit_init   = '0;
    hit_kill   = '0;
    hit_commit = '0;
    hit_stall  = '0;
    hit_bar    = '0;
    hit_issue  = '0;
    valid_d    = valid_q;
    for (int i = 0; i < NUM_WARPS; i++) begin
      pc_d[i]       = pc_q[i];
      mask_d[i]     = mask_q[i];
      status_d[i]   = status_q[i];
      age_d[i]      = age_q[i];
      cnt_d[i]      = (cnt_q[i] != '0) ? cnt_q[i] - STALL_WIDTH'(1) : '0;
      live[i]       = valid_q[i] && status_q[i] != ST_DONE;
      hit_init[i]   = init_valid && init_id == WID_W'(i);
      hit_kill[i]   = live[i] && kill_valid && kill_id == WID_W'(i);
      hit_commit[i] = live[i] && commit_valid && commit_id == WID_W'(i);
      hit_stall[i]  = live[i] && stall_valid && stall_id == WID_W'(i) && stall_cycles != '0;
      hit_bar[i]    = live[i] && bar_valid && bar_id == WID_W'(i);
      hit_issue[i]  = live[i] && issue_valid && issue_id == WID_W'(i);

      if (hit_issue[i])
        age_d[i] = '0;
      else if (issue_valid && valid_q[i] && status_q[i] == ST_READY && age_q[i] != AGE_MAX)
        age_d[i] = age_q[i] + AGE_WIDTH'(1);

      if (hit_init[i]) begin
        pc_d[i]     = init_pc;
        mask_d[i]   = init_mask;
        status_d[i] = ST_READY;
        age_d[i]    = '0;
        cnt_d[i]    = '0;
        valid_d[i]  = 1'b1;
      end else begin
        if (hit_commit[i] && !hit_kill[i]) begin
          pc_d[i] = commit_pc;
          if (commit_mask_we) mask_d[i] = commit_mask;
        end
        if (hit_kill[i])
          status_d[i] = ST_DONE;
        else if (hit_commit[i] && commit_mask_we && commit_mask == '0)
          status_d[i] = ST_DONE;
        else if (hit_stall[i]) begin
          status_d[i] = ST_STALLED;
          cnt_d[i]    = stall_cycles;
        end else if (hit_bar[i])
          status_d[i] = ST_BARRIER;
        else if (status_q[i] == ST_STALLED && cnt_q[i] == STALL_WIDTH'(1))
          status_d[i] = ST_READY;
        else if (rel_fire && status_q[i] == ST_BARRIER)
          status_d[i] = ST_READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i]     <= '0;
        mask_q[i]   <= '0;
        status_q[i] <= ST_IDLE;
        age_q[i]    <= '0;
        cnt_q[i]    <= '0;
      end
      valid_q     <= '0;
      bar_release <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      status_q    <= status_d;
      age_q       <= age_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      bar_release <= rel_fire;
    end
  end

  always_comb begin
    pc_flat     = '0;
    mask_flat   = '0;
    status_flat = '0;
    age_flat    = '0;
    ready_mask  = '0;
    done_mask   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      pc_flat[i*PC_WIDTH +: PC_WIDTH]     = pc_q[i];
      mask_flat[i*WARP_SIZE +: WARP_SIZE] = mask_q[i];
      status_flat[i*3 +: 3]               = status_q[i];
      age_flat[i*AGE_WIDTH +: AGE_WIDTH]  = age_q[i];
      ready_mask[i] = valid_q[i] && status_q[i] == ST_READY;
      done_mask[i]  = valid_q[i] && status_q[i] == ST_DONE;
    end
  end

  assign valid_mask = valid_q;
  assign all_done   = (|valid_q) && ((valid_q & ~done_mask) == '0);

endmodule

// File: tb/tb_warp_context_ctrl.sv
// Scoreboard bench for warp_context_ctrl: stimulus queues expectations per cycle,
// a negedge monitor compares them and matches every bar_release pulse to an expected cycle.
module tb_warp_context_ctrl;
  localparam int NW = 8, WS = 32, PW = 32, AW = 8, SW = 6, WW = 3;
  localparam int K_STAT = 0, K_PC = 1, K_MASK = 2, K_AGE = 3, K_VALID = 4,
                 K_READY = 5, K_DONE = 6, K_ALLD = 7, K_BREL = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic init_valid, commit_valid, commit_mask_we, stall_valid, bar_valid, kill_valid, issue_valid;
  logic [WW-1:0] init_id, commit_id, stall_id, bar_id, kill_id, issue_id;
  logic [PW-1:0] init_pc, commit_pc;
  logic [WS-1:0] init_mask, commit_mask;
  logic [SW-1:0] stall_cycles;
  logic [NW*PW-1:0] pc_flat;
  logic [NW*WS-1:0] mask_flat;
  logic [NW*3-1:0]  status_flat;
  logic [NW*AW-1:0] age_flat;
  logic [NW-1:0]    valid_mask, ready_mask, done_mask;
  logic             all_done, bar_release;

  warp_context_ctrl #(.NUM_WARPS(NW), .WARP_SIZE(WS), .PC_WIDTH(PW), .AGE_WIDTH(AW),
                      .STALL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .init_valid(init_valid), .init_id(init_id), .init_pc(init_pc), .init_mask(init_mask),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_pc(commit_pc),
    .commit_mask_we(commit_mask_we), .commit_mask(commit_mask),
    .stall_valid(stall_valid), .stall_id(stall_id), .stall_cycles(stall_cycles),
    .bar_valid(bar_valid), .bar_id(bar_id), .kill_valid(kill_valid), .kill_id(kill_id),
    .issue_valid(issue_valid), .issue_id(issue_id),
    .pc_flat(pc_flat), .mask_flat(mask_flat), .status_flat(status_flat), .age_flat(age_flat),
    .valid_mask(valid_mask), .ready_mask(ready_mask), .done_mask(done_mask),
    .all_done(all_done), .bar_release(bar_release));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          wid;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   rel_q[$];
  int   n_checks = 0, n_fail = 0;

  function automatic logic [63:0] get_val(input int kind, input int w);
    case (kind)
      K_STAT:  return 64'(status_flat[w*3 +: 3]);
      K_PC:    return 64'(pc_flat[w*PW +: PW]);
      K_MASK:  return 64'(mask_flat[w*WS +: WS]);
      K_AGE:   return 64'(age_flat[w*AW +: AW]);
      K_VALID: return 64'(valid_mask);
      K_READY: return 64'(ready_mask);
      K_DONE:  return 64'(done_mask);
      K_ALLD:  return 64'(all_done);
      default: return 64'(bar_release);
    endcase
  endfunction

  task automatic expect_at(input int d, input string name, input int kind, input int w,
                           input logic [63:0] v);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = kind;
    e.wid  = w;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    logic [63:0] a;
    int          e;
    forever begin
      @(negedge clk);
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          a = get_val(sb[k].kind, sb[k].wid);
          n_checks++;
          if (a !== sb[k].exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", sb[k].name, a, sb[k].exp, cyc);
          end
          sb.delete(k);
        end
      end
      if (bar_release === 1'b1) begin
        n_checks++;
        if (rel_q.size() == 0) begin
          n_fail++;
          $display("FAIL bar_release_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = rel_q.pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL bar_release_pulse: got pulse at cycle %0d expected cycle %0d", cyc, e);
          end
        end
      end
    end
  end

  task automatic clr();
    init_valid = 0; init_id = '0; init_pc = '0; init_mask = '0;
    commit_valid = 0; commit_id = '0; commit_pc = '0; commit_mask_we = 0; commit_mask = '0;
    stall_valid = 0; stall_id = '0; stall_cycles = '0;
    bar_valid = 0; bar_id = '0; kill_valid = 0; kill_id = '0;
    issue_valid = 0; issue_id = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input int w, input logic [PW-1:0] pc, input logic [WS-1:0] m);
    init_valid = 1; init_id = WW'(w); init_pc = pc; init_mask = m;
    tick(); clr();
  endtask

  task automatic do_kill(input int w);
    kill_valid = 1; kill_id = WW'(w);
    tick(); clr();
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    expect_at(0, "rst_valid", K_VALID, 0, 0);
    expect_at(0, "rst_status2", K_STAT, 2, 0);
    expect_at(0, "rst_pc2", K_PC, 2, 0);
    expect_at(0, "rst_mask2", K_MASK, 2, 0);
    expect_at(0, "rst_all_done", K_ALLD, 0, 0);
    expect_at(0, "rst_bar_release", K_BREL, 0, 0);
    tick();

    init_valid = 1; init_id = 2; init_pc = 32'h100; init_mask = 32'hFFFF_FFFF;
    expect_at(1, "init_status2", K_STAT, 2, 1);
    expect_at(1, "init_valid", K_VALID, 0, 64'h04);
    expect_at(1, "init_ready", K_READY, 0, 64'h04);
    expect_at(1, "init_age2", K_AGE, 2, 0);
    expect_at(1, "init_pc2", K_PC, 2, 64'h100);
    expect_at(1, "init_mask2", K_MASK, 2, 64'hFFFF_FFFF);
    tick(); clr();

    do_init(1, 32'h10, 32'h1);
    stall_valid = 1; stall_id = 1; stall_cycles = 3;
    expect_at(1, "stall_c1", K_STAT, 1, 2);
    expect_at(2, "stall_c2", K_STAT, 1, 2);
    expect_at(3, "stall_c3", K_STAT, 1, 2);
    expect_at(4, "stall_expire", K_STAT, 1, 1);
    tick(); clr();
    repeat (3) tick();
    stall_valid = 1; stall_id = 1; stall_cycles = 0;
    expect_at(1, "stall_zero", K_STAT, 1, 1);
    tick(); clr();

    do_init(0, 32'h200, 32'hFF);
    do_init(3, 32'h300, 32'hF0F0);
    do_init(5, 32'h500, 32'h1);
    do_kill(5);
    do_kill(2);
    bar_valid = 1; bar_id = 0;
    expect_at(1, "bar0_status", K_STAT, 0, 3);
    expect_at(2, "bar0_no_release", K_BREL, 0, 0);
    tick(); clr();
    bar_valid = 1; bar_id = 1;
    tick(); clr();
    bar_valid = 1; bar_id = 3;
    expect_at(1, "bar3_status", K_STAT, 3, 3);
    expect_at(1, "bar3_no_early_rel", K_BREL, 0, 0);
    expect_at(2, "rel_status0", K_STAT, 0, 1);
    expect_at(2, "rel_status1", K_STAT, 1, 1);
    expect_at(2, "rel_status3", K_STAT, 3, 1);
    expect_at(2, "rel_ready", K_READY, 0, 64'h0B);
    expect_at(2, "rel_done", K_DONE, 0, 64'h24);
    expect_at(2, "rel_valid", K_VALID, 0, 64'h2F);
    expect_at(2, "rel_pulse_hi", K_BREL, 0, 1);
    expect_at(3, "rel_pulse_lo", K_BREL, 0, 0);
    rel_q.push_back(cyc + 2);
    tick(); clr();
    repeat (2) tick();

    do_init(4, 32'h44, 32'hF);
    kill_valid = 1; kill_id = 4;
    commit_valid = 1; commit_id = 4; commit_pc = 32'h40;
    stall_valid = 1; stall_id = 4; stall_cycles = 5;
    expect_at(1, "prio_status4", K_STAT, 4, 4);
    expect_at(1, "prio_pc4", K_PC, 4, 64'h44);
    expect_at(1, "prio_mask4", K_MASK, 4, 64'hF);
    tick(); clr();
    commit_valid = 1; commit_id = 3; commit_pc = 32'h80; commit_mask_we = 1; commit_mask = '0;
    expect_at(1, "commit0_status3", K_STAT, 3, 4);
    expect_at(1, "commit0_pc3", K_PC, 3, 64'h80);
    expect_at(1, "commit0_mask3", K_MASK, 3, 0);
    tick(); clr();

    do_init(6, 32'h600, 32'h3);
    stall_valid = 1; stall_id = 6; stall_cycles = 60;
    tick(); clr();
    issue_valid = 1; issue_id = 0;
    expect_at(10, "age1_10", K_AGE, 1, 10);
    expect_at(10, "age6_stalled", K_AGE, 6, 0);
    expect_at(10, "age0_issued", K_AGE, 0, 0);
    repeat (10) tick();
    expect_at(244, "age1_254", K_AGE, 1, 254);
    repeat (244) tick();
    expect_at(6, "age1_sat", K_AGE, 1, 255);
    repeat (6) tick();
    clr();

    bar_valid = 1; bar_id = 6;
    tick(); clr();
    stall_valid = 1; stall_id = 1; stall_cycles = 5;
    bar_valid = 1; bar_id = 0;
    tick(); clr();
    expect_at(0, "pre_rst_status1", K_STAT, 1, 2);
    expect_at(0, "pre_rst_status0", K_STAT, 0, 3);
    expect_at(0, "pre_rst_valid", K_VALID, 0, 64'h7F);
    @(negedge clk);
    #2 rst = 1;
    #2 rst = 0;
    expect_at(1, "arst_status1", K_STAT, 1, 0);
    expect_at(1, "arst_status0", K_STAT, 0, 0);
    expect_at(1, "arst_valid", K_VALID, 0, 0);
    expect_at(1, "arst_pc1", K_PC, 1, 0);
    expect_at(1, "arst_mask1", K_MASK, 1, 0);
    expect_at(1, "arst_age1", K_AGE, 1, 0);
    expect_at(1, "arst_ready", K_READY, 0, 0);
    for (int d = 1; d <= 6; d++) expect_at(d, "arst_no_release", K_BREL, 0, 0);
    expect_at(6, "arst_status1_late", K_STAT, 1, 0);
    repeat (6) tick();

    do_init(7, 32'h700, 32'h1);
    expect_at(0, "alldone_lo", K_ALLD, 0, 0);
    expect_at(0, "alldone_valid", K_VALID, 0, 64'h80);
    kill_valid = 1; kill_id = 7;
    expect_at(1, "alldone_hi", K_ALLD, 0, 1);
    expect_at(1, "alldone_done", K_DONE, 0, 64'h80);
    tick(); clr();
    repeat (2) tick();

    foreach (sb[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no sample expected 0x%0h at cycle %0d", sb[k].name, sb[k].exp, sb[k].cyc);
    end
    foreach (rel_q[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL bar_release_missing: got no pulse expected one at cycle %0d", rel_q[k]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus expected it within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
